c_done_sync: RTL and testbench
==============================

# c_done_sync

Clocked consumer for the asynchronous C-element completion tree. It synchronises the tree's single completion output `done` into the `clk` domain and presents each completed token to synchronous logic as a valid/ready transfer. It also drives the four-phase acknowledge `ack` back to the upstream senders, so the tree can return to spacer. It sits directly downstream of the C-element tree, between the async datapath and the clocked control logic.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `done`; legal values are 2 or more.
- `CNT_W`, 8: width of the completed-token counter.
- `TIMEOUT`, 200: watchdog limit in cycles. Used only when `C_DONE_SYNC_TIMEOUT_EN` is defined; legal range is 1 to 2^16-1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `done`  in  1  completion output of the C-element tree; asynchronous to `clk`.
- `ready`  in  1  downstream accepts the token.
- `valid`  out  1  a token is complete and waiting.
- `ack`  out  1  four-phase acknowledge to the upstream senders.
- `proto_err`  out  1  one-cycle pulse when `done` falls before the token is accepted.
- `timeout`  out  1  sticky watchdog flag.
- `tok_cnt`  out  CNT_W  number of fully completed four-phase cycles; wraps modulo 2^CNT_W.

## Operation
- **Synchroniser:** `done_s` is `done` delayed through `SYNC_STAGES` flops. It is the only use of `done`.
- **FSM:** three states, IDLE, VALID and RETURN, held in registers. All outputs are registered.
- **IDLE:**
  - `valid`=0 and `ack`=0.
  - If `done_s`=1, go to VALID and set `valid`=1.
  - The test is on level, not edge, so `done` already high at reset release produces a token.
- **VALID:**
  - `valid` is held high.
  - If `ready`=1, go to RETURN, set `valid`=0 and `ack`=1.
  - Else if `done_s`=0, go to IDLE, set `valid`=0 and pulse `proto_err` for one cycle. `tok_cnt` is not changed.
  - If `ready`=1 and `done_s`=0 in the same cycle, acceptance wins.
- **RETURN:**
  - `ack` is held high.
  - If `done_s`=0, go to IDLE, set `ack`=0 and increment `tok_cnt` by 1.
- `tok_cnt` wraps from 2^CNT_W-1 to 0 with no flag.
- `ready` is ignored outside VALID.

## Timing
- **Reset values:** while `rst`=0 all of the following are forced:
  - `valid`=0, `ack`=0, `proto_err`=0, `timeout`=0, `tok_cnt`=0;
  - state IDLE;
  - synchroniser flops and watchdog counter 0.
- **Reset mid-operation:** reset in any state drops `ack` and `valid` immediately (asynchronous assertion). Reset removal must be synchronised externally.
- **Latency:** from `done` rising to `valid`=1 is `SYNC_STAGES`+1 rising edges, at most one extra cycle for metastability resolution.
- **Accept:** `valid`&`ready` at edge N gives `ack`=1 and `valid`=0 after edge N.
- **Release:** from `done` falling to `ack`=0 is `SYNC_STAGES`+1 edges. `tok_cnt` updates on the same edge.
- **Minimum period:** one full token takes at least 2*`SYNC_STAGES`+3 cycles.
- `valid` never asserts while `ack`=1, and `ack` never asserts in IDLE.

## Configuration
- **Macro:** `C_DONE_SYNC_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit watchdog counter clears on entry to RETURN and increments each cycle in RETURN.
  - When the count reaches `TIMEOUT` with `done_s` still 1, `timeout` is set.
  - `timeout` stays set until `rst`. The FSM keeps waiting in RETURN.
- **Undefined:** no counter is built and `timeout` is tied to 0.

## Test plan
- **Basic token:** reset, then `done`=1 with `ready`=1.
  - `valid` is high 3 cycles after `done`.
  - `ack`=1 the next cycle.
  - Drop `done`: `ack`=0 3 cycles later and `tok_cnt`=1.
- **Backpressure:** `done`=1, `ready`=0 for 10 cycles, then `ready`=1.
  - `valid` is held for all 10 cycles.
  - `ack` rises exactly one cycle after `ready`.
- **Protocol error:** `done`=1 until `valid`, then `done`=0 with `ready`=0.
  - `proto_err` pulses once.
  - `valid` goes to 0 and `tok_cnt` is unchanged.
  - Also drive `ready`=1 and `done_s` falling in the same cycle: acceptance wins and there is no `proto_err`.
- **Wrap:** with `CNT_W`=2, run 5 tokens; `tok_cnt` reads 1,2,3,0,1.
- **Reset mid-token:** assert `rst`=0 while in RETURN.
  - `ack`=0 and `tok_cnt`=0 immediately.
  - Release with `done`=1: a new token appears (level start).
- **Watchdog:** macro defined, `TIMEOUT`=20, hold `done`=1 after accept.
  - `timeout`=1 after 20 cycles in RETURN and stays 1.
  - With the macro undefined, `timeout` stays 0.

Source files
------------

// File: rtl/c_done_sync.sv
// rtl/c_done_sync.sv - clocked consumer for the C-element completion tree
// Optional watchdog: define C_DONE_SYNC_TIMEOUT_EN to build the RETURN-state timeout.
module c_done_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic             ready,
  output logic             valid,
  output logic             ack,
  output logic             proto_err,
  output logic             timeout,
  output logic [CNT_W-1:0] tok_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VALID  = 2'd1,
    S_RETURN = 2'd2
  } state_t;

  // Reject parameter values the synchroniser or watchdog cannot honour.
  if (SYNC_STAGES < 2 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("c_done_sync: illegal SYNC_STAGES or TIMEOUT");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   done_s;
  state_t                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic                   ack_q, ack_d;
  logic                   proto_err_q, proto_err_d;
  logic [CNT_W-1:0]       tok_cnt_q, tok_cnt_d;

  // Multi-flop synchroniser; done_s is the only view of done inside the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], done};
    end
  end

  assign done_s = sync_q[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: level-triggered start, acceptance has priority over a falling done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (done_s) state_d = S_VALID;
      S_VALID: begin
        if (ready)        state_d = S_RETURN;
        else if (!done_s) state_d = S_IDLE;
      end
      S_RETURN: if (!done_s) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output next values; outputs follow the destination state so they stay registered.
  always_comb begin
    valid_d     = (state_d == S_VALID);
    ack_d       = (state_d == S_RETURN);
    proto_err_d = (state_q == S_VALID) && !ready && !done_s;
    tok_cnt_d   = tok_cnt_q;
    if (state_q == S_RETURN && !done_s) begin
      tok_cnt_d = tok_cnt_q + CNT_W'(1);
    end
  end

  // Output registers; the token counter wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      proto_err_q <= 1'b0;
      tok_cnt_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      proto_err_q <= proto_err_d;
      tok_cnt_q   <= tok_cnt_d;
    end
  end

  assign valid     = valid_q;
  assign ack       = ack_q;
  assign proto_err = proto_err_q;
  assign tok_cnt   = tok_cnt_q;

`ifdef C_DONE_SYNC_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Watchdog: restart on entry to RETURN, count while there; flag is sticky until reset.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (state_q != S_RETURN && state_d == S_RETURN) begin
      wd_d = '0;
    end else if (state_q == S_RETURN && wd_q != 16'hFFFF) begin
      wd_d = wd_q + 16'd1;
    end
    if (state_q == S_RETURN && done_s && wd_q == 16'(TIMEOUT - 1)) begin
      timeout_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_c_done_sync.sv
// tb/tb_c_done_sync.sv - scoreboard bench for c_done_sync
module tb_c_done_sync;

  localparam int EV_VALID = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_PERR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done = 1'b0;
  logic       ready = 1'b0;
  logic       valid, ack, proto_err, timeout;
  logic [1:0] tok_cnt;

  typedef struct {
    int kind;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  inv_err = 0;
  logic pv = 1'b0;
  logic pa = 1'b0;

  c_done_sync #(.SYNC_STAGES(2), .CNT_W(2), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .done(done), .ready(ready),
    .valid(valid), .ack(ack), .proto_err(proto_err),
    .timeout(timeout), .tok_cnt(tok_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int kind, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d tok_cnt %0d expected none", kind, tok_cnt);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_tok_cnt", int'(tok_cnt), e.cnt);
    end
  endtask

  // Monitor: turn output edges into events and compare with the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
      pa = 1'b0;
    end else begin
      if (valid && ack) inv_err++;
      if (valid && !pv) got(EV_VALID);
      if (!ack && pa) got(EV_DONE);
      if (proto_err) got(EV_PERR);
      pv = valid;
      pa = ack;
    end
  end

  function automatic logic sig(input int w);
    return (w == 0) ? valid : ack;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count rising edges until the selected output reaches val; -1 on budget expiry.
  task automatic wait_sig(input int w, input logic val, input int max, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (sig(w) == val) break;
      if (n >= max) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic run_token(input int cnt_before, input int cnt_after);
    int n;
    push(EV_VALID, cnt_before);
    done = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("tok_valid_latency", n, 3);
    step();
    chk("tok_ack_after_accept", int'({ack, valid}), 2);
    push(EV_DONE, cnt_after);
    done = 1'b0;
    wait_sig(1, 1'b0, 20, n);
    chk("tok_release_latency", n, 3);
    chk("tok_cnt_after", int'(tok_cnt), cnt_after);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int held;
    // Reset state
    repeat (3) step();
    chk("rst_valid", int'(valid), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_proto_err", int'(proto_err), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_tok_cnt", int'(tok_cnt), 0);
    rst = 1'b1;
    repeat (2) step();

    // Basic token
    ready = 1'b1;
    run_token(0, 1);
    repeat (2) step();

    // Backpressure
    ready = 1'b0;
    push(EV_VALID, 1);
    done = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("bp_valid_latency", n, 3);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid && !ack) held++;
    end
    chk("bp_valid_held", held, 10);
    ready = 1'b1;
    step();
    chk("bp_ack_one_cycle", int'({ack, valid}), 2);
    ready = 1'b0;
    push(EV_DONE, 2);
    done = 1'b0;
    wait_sig(1, 1'b0, 20, n);
    chk("bp_release_latency", n, 3);
    chk("bp_tok_cnt", int'(tok_cnt), 2);
    repeat (2) step();

    // Protocol error: done drops while valid waits
    push(EV_VALID, 2);
    done = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    push(EV_PERR, 2);
    done = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    chk("perr_valid_drop", n, 3);
    chk("perr_pulse", int'(proto_err), 1);
    step();
    chk("perr_one_cycle", int'(proto_err), 0);
    chk("perr_tok_cnt", int'(tok_cnt), 2);
    repeat (2) step();

    // Acceptance wins over done_s falling in the same cycle
    push(EV_VALID, 2);
    done = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    push(EV_DONE, 3);
    done = 1'b0;
    step();
    step();
    ready = 1'b1;
    step();
    chk("tie_accept", int'({ack, valid, proto_err}), 4);
    step();
    chk("tie_release", int'(ack), 0);
    chk("tie_tok_cnt", int'(tok_cnt), 3);
    repeat (2) step();

    // Wrap with a 2-bit counter
    run_token(3, 0);
    run_token(0, 1);
    run_token(1, 2);
    repeat (2) step();

    // Reset while in RETURN, released with done still high
    push(EV_VALID, 2);
    done = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    step();
    chk("mid_in_return", int'(ack), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", int'(ack), 0);
    chk("mid_rst_tok_cnt", int'(tok_cnt), 0);
    push(EV_VALID, 0);
    step();
    rst = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("mid_level_start", n, 3);
    step();
    chk("mid_ack", int'(ack), 1);
    push(EV_DONE, 1);
    done = 1'b0;
    wait_sig(1, 1'b0, 20, n);
    chk("mid_tok_cnt", int'(tok_cnt), 1);
    repeat (2) step();

    // Watchdog: hold done after accept
    push(EV_VALID, 1);
    done = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    step();
    chk("wd_ack", int'(ack), 1);
`ifdef C_DONE_SYNC_TIMEOUT_EN
    repeat (19) step();
    chk("wd_before_limit", int'(timeout), 0);
    step();
    chk("wd_at_limit", int'(timeout), 1);
    repeat (5) step();
    chk("wd_sticky", int'(timeout), 1);
`else
    repeat (30) step();
    chk("wd_disabled", int'(timeout), 0);
`endif
    push(EV_DONE, 2);
    done = 1'b0;
    wait_sig(1, 1'b0, 20, n);
    chk("wd_release_latency", n, 3);
    chk("wd_tok_cnt", int'(tok_cnt), 2);
`ifdef C_DONE_SYNC_TIMEOUT_EN
    chk("wd_sticky_idle", int'(timeout), 1);
`else
    chk("wd_disabled_idle", int'(timeout), 0);
`endif

    @(negedge clk);
    #1;
    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("valid_ack_exclusive", inv_err, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
